// File: rtl/audio_adc_if.sv
// Codec ADC pins and parallel audio word bundle for audio_adc_deserializer.
// peak_level exists only when AUD_PEAK_DETECT_EN is defined.
`timescale 1ns/1ps
interface audio_adc_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic                      aud_bclk;
   logic                      aud_adclrck;
   logic                      aud_adcdat;
   logic [2*SAMPLE_WIDTH-1:0] aud_dat_export;
   logic                      adc_lr_clk_export;
   logic                      sample_valid;
   logic                      frame_error;
`ifdef AUD_PEAK_DETECT_EN
   logic [SAMPLE_WIDTH-1:0]   peak_level;
`endif

   modport master (
      input  aud_bclk,
      input  aud_adclrck,
      input  aud_adcdat,
      output aud_dat_export,
      output adc_lr_clk_export,
      output sample_valid,
      output frame_error
`ifdef AUD_PEAK_DETECT_EN
      , output peak_level
`endif
   );

   modport slave (
      output aud_bclk,
      output aud_adclrck,
      output aud_adcdat,
      input  aud_dat_export,
      input  adc_lr_clk_export,
      input  sample_valid,
      input  frame_error
`ifdef AUD_PEAK_DETECT_EN
      , input peak_level
`endif
   );
endinterface

// File: rtl/audio_adc_deserializer.sv
// I2S ADC capture into {left,right} parallel words in the clk_clk domain.
// Optional peak meter output enabled by defining AUD_PEAK_DETECT_EN.
`timescale 1ns/1ps
module audio_adc_deserializer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   audio_adc_if.master aud
);
   localparam int W  = SAMPLE_WIDTH;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [2:0] {
      SYNC, L_DLY, L_SHIFT, R_DLY, R_SHIFT
   } state_e;

   state_e state_q, state_d;
   logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
   logic          bclk_prev_q, bclk_prev_d;
   logic          lrck_q, lrck_d;
   logic          lrx_q, lrx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  left_q, left_d;
   logic [W-1:0]  right_q, right_d;
   logic [2*W-1:0] dat_q, dat_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          bclk_s, lrck_s, dat_s;
   logic          bclk_rise, lrck_chg;
`ifdef AUD_PEAK_DETECT_EN
   logic [W-1:0]  peak_q, peak_d;
   logic [W-1:0]  abs_l, abs_r;

   // Most negative code saturates so the result fits W-1 magnitude bits
   function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
      if (x == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
      else if (x[W-1])                return ~x + W'(1);
      else                            return x;
   endfunction
`endif

   assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
   assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
   assign dat_s     = dat_sync_q[SYNC_STAGES-1];
   assign bclk_rise = bclk_s & ~bclk_prev_q;
   assign lrck_chg  = bclk_rise & (lrck_s ^ lrck_q);

   always_comb begin
      bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], aud.aud_bclk};
      lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], aud.aud_adclrck};
      dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], aud.aud_adcdat};
      bclk_prev_d = bclk_s;
      lrx_d       = lrck_s;
      state_d     = state_q;
      lrck_d      = lrck_q;
      cnt_d       = cnt_q;
      left_d      = left_q;
      right_d     = right_q;
      dat_d       = dat_q;
      valid_d     = 1'b0;
      err_d       = err_q;
      if (bclk_rise) begin
         lrck_d = lrck_s;
         // A slot boundary takes priority over any data bit on the same rise
         unique case (state_q)
            SYNC: begin
               if (lrck_chg && !lrck_s) state_d = L_DLY;
            end
            L_DLY, R_DLY: begin
               if (lrck_chg) begin
                  err_d   = 1'b1;
                  state_d = SYNC;
               end else begin
                  cnt_d   = '0;
                  state_d = (state_q == L_DLY) ? L_SHIFT : R_SHIFT;
               end
            end
            L_SHIFT: begin
               if (lrck_chg) begin
                  if (cnt_q == CNT_FULL) state_d = R_DLY;
                  else begin
                     err_d   = 1'b1;
                     state_d = SYNC;
                  end
               end else if (cnt_q < CNT_FULL) begin
                  left_d = {left_q[W-2:0], dat_s};
                  cnt_d  = cnt_q + CW'(1);
               end
            end
            R_SHIFT: begin
               if (lrck_chg) begin
                  if (cnt_q == CNT_FULL) state_d = L_DLY;
                  else begin
                     err_d   = 1'b1;
                     state_d = SYNC;
                  end
               end else if (cnt_q < CNT_FULL) begin
                  right_d = {right_q[W-2:0], dat_s};
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == CNT_LAST) begin
                     dat_d   = {left_q, right_d};
                     valid_d = 1'b1;
                  end
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

`ifdef AUD_PEAK_DETECT_EN
   always_comb begin
      abs_l  = abs_sat(dat_d[2*W-1:W]);
      abs_r  = abs_sat(dat_d[W-1:0]);
      peak_d = peak_q;
      if (valid_d) peak_d = (abs_l > abs_r) ? abs_l : abs_r;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) peak_q <= '0;
      else             peak_q <= peak_d;
   end

   assign aud.peak_level = peak_q;
`endif

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         dat_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lrx_q       <= 1'b0;
         state_q     <= SYNC;
         lrck_q      <= 1'b0;
         cnt_q       <= '0;
         left_q      <= '0;
         right_q     <= '0;
         dat_q       <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         bclk_sync_q <= bclk_sync_d;
         lrck_sync_q <= lrck_sync_d;
         dat_sync_q  <= dat_sync_d;
         bclk_prev_q <= bclk_prev_d;
         lrx_q       <= lrx_d;
         state_q     <= state_d;
         lrck_q      <= lrck_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         right_q     <= right_d;
         dat_q       <= dat_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign aud.aud_dat_export    = dat_q;
   assign aud.adc_lr_clk_export = lrx_q;
   assign aud.sample_valid      = valid_q;
   assign aud.frame_error       = err_q;
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Scoreboard bench for audio_adc_deserializer driven by an I2S codec model.
// Peak checks are active when AUD_PEAK_DETECT_EN is defined.
`timescale 1ns/1ps
module tb_audio_adc_deserializer;
   localparam int W  = 16;
   localparam int HB = 160;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   audio_adc_if #(.SAMPLE_WIDTH(W)) aif ();

   audio_adc_deserializer #(
      .SAMPLE_WIDTH(W),
      .SYNC_STAGES (2)
   ) dut (
      .clk_clk    (clk),
      .reset_reset(rst),
      .aud        (aif)
   );

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   pk_q[$];
   logic           rst_at_edge = 1'b1;
   logic [2*W-1:0] hold = '0;

   always @(posedge clk) rst_at_edge <= rst;

   // Monitor: reset state, scoreboard pops on sample_valid, hold between pulses
   always @(negedge clk) begin
      if (rst_at_edge) begin
         checks++;
         if (aif.aud_dat_export != '0 || aif.adc_lr_clk_export ||
             aif.sample_valid || aif.frame_error) begin
            errors++;
            $display("FAIL reset_state: got dat=%h lr=%b v=%b err=%b, want all 0",
                     aif.aud_dat_export, aif.adc_lr_clk_export,
                     aif.sample_valid, aif.frame_error);
         end
`ifdef AUD_PEAK_DETECT_EN
         checks++;
         if (aif.peak_level != '0) begin
            errors++;
            $display("FAIL reset_peak: got %h, want 0", aif.peak_level);
         end
`endif
         hold = '0;
      end else if (aif.sample_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got dat=%h, want no pulse",
                     aif.aud_dat_export);
            hold = aif.aud_dat_export;
         end else begin
            logic [2*W-1:0] e;
            logic [W-1:0]   p;
            e = exp_q.pop_front();
            p = pk_q.pop_front();
            if (aif.aud_dat_export != e) begin
               errors++;
               $display("FAIL frame_word: got %h, want %h", aif.aud_dat_export, e);
            end
`ifdef AUD_PEAK_DETECT_EN
            checks++;
            if (aif.peak_level != p) begin
               errors++;
               $display("FAIL peak_level: got %h, want %h", aif.peak_level, p);
            end
`else
            if (p == '1) hold = e;
`endif
            hold = e;
         end
      end else begin
         checks++;
         if (aif.aud_dat_export != hold) begin
            errors++;
            $display("FAIL hold_word: got %h, want %h", aif.aud_dat_export, hold);
            hold = aif.aud_dat_export;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // One bclk period; lrck and data change while bclk is low
   task automatic rise(input logic lr, input logic d);
      aif.aud_adclrck = lr;
      aif.aud_adcdat  = d;
      aif.aud_bclk    = 1'b0;
      #HB;
      aif.aud_bclk    = 1'b1;
      #HB;
   endtask

   // Rise 0 carries the lrck edge, rise 1 is the delay bit, rises 2.. the word
   task automatic send_slot(input logic lr, input logic [W-1:0] w, input int nb);
      for (int i = 0; i < nb; i++) begin
         logic b;
         b = (i >= 2 && i < 2 + W) ? w[W+1-i] : 1'($urandom);
         rise(lr, b);
      end
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                             input logic [W-1:0] pk, input bit expect_it);
      if (expect_it) begin
         exp_q.push_back({l, r});
         pk_q.push_back(pk);
      end
      send_slot(1'b0, l, 32);
      send_slot(1'b1, r, 32);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, want finish");
      $fatal(1);
   end

   initial begin
      aif.aud_bclk    = 1'b0;
      aif.aud_adclrck = 1'b0;
      aif.aud_adcdat  = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;

      // Partial right slot before any left slot: must be discarded
      send_slot(1'b1, 16'hDEAD, 12);

      send_frame(16'h1234, 16'hFEDC, 16'h1234, 1'b1);
      chk("frame_error_clean", 32'(aif.frame_error), 32'd0);
      chk("lr_export_right", 32'(aif.adc_lr_clk_export), 32'd1);

      send_frame(16'h8000, 16'h7FFF, 16'h7FFF, 1'b1);
      send_frame(16'h0001, 16'hFFFF, 16'h0001, 1'b1);
      send_frame(16'hAAAA, 16'h5555, 16'h5556, 1'b1);
      chk("queue_after_burst", 32'(exp_q.size()), 32'd0);

      // Left slot cut after 10 rises (8 data bits)
      send_slot(1'b0, 16'hFFFF, 10);
      send_slot(1'b1, 16'h1111, 32);
      chk("frame_error_set", 32'(aif.frame_error), 32'd1);
      send_frame(16'h0F0F, 16'hF0F1, 16'h0F0F, 1'b1);
      chk("frame_error_sticky", 32'(aif.frame_error), 32'd1);
      chk("queue_after_short", 32'(exp_q.size()), 32'd0);

      fork
         send_frame(16'h4321, 16'h8001, 16'h7FFF, 1'b0);
         begin
            #(2 * HB * 8);
            @(negedge clk) rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            @(negedge clk);
            chk("frame_error_cleared", 32'(aif.frame_error), 32'd0);
            chk("dat_after_reset", aif.aud_dat_export, 32'd0);
         end
      join
      send_frame(16'h5A5A, 16'hA5A5, 16'h5A5B, 1'b1);
      chk("queue_after_reset", 32'(exp_q.size()), 32'd0);

      send_frame(16'h8000, 16'h0100, 16'h7FFF, 1'b1);
      send_frame(16'hFF00, 16'h0050, 16'h0100, 1'b1);
      chk("final_word", aif.aud_dat_export, 32'hFF000050);
      chk("final_frame_error", 32'(aif.frame_error), 32'd0);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef AUD_PEAK_DETECT_EN
      chk("final_peak", 32'(aif.peak_level), 32'h0100);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
